// File: rtl/filter_gpu_pkg.sv
// filter_gpu_pkg: shared lane widths and the three-lane store triplet type.
package filter_gpu_pkg;
    localparam int LANES  = 3;
    localparam int DATA_W = 18;
    localparam int ADDR_W = 10;
    typedef logic [DATA_W-1:0] lane_data_t;
    typedef logic [ADDR_W-1:0] lane_addr_t;
    typedef struct packed {
        lane_addr_t [LANES-1:0] addr;
        lane_data_t [LANES-1:0] data;
    } store_triplet_t;
endpackage

// File: rtl/triplet_fifo.sv
// triplet_fifo: store-triplet FIFO; full/empty come from the level count, not pointer equality.
module triplet_fifo
    import filter_gpu_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  store_triplet_t           push_data_i,
    input  logic                     pop_i,
    output store_triplet_t           head_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    store_triplet_t mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          push_ok, pop_ok;
    always_comb begin
        full_o   = level_q == LW'(DEPTH);
        empty_o  = level_q == '0;
        push_ok  = push_i && !full_o;
        pop_ok   = pop_i && !empty_o;
        wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + PW'(1) : rd_ptr_q;
        level_d  = level_q + LW'(push_ok) - LW'(pop_ok);
        head_o   = mem_q[rd_ptr_q];
        level_o  = level_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst && push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end
endmodule

// File: rtl/write_serializer.sv
// write_serializer: buffers three-lane stores and replays them as lane 0,1,2 beats on a valid/ready stream.
module write_serializer
    import filter_gpu_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          MemWriteM,
    input  logic [ADDR_W-1:0]             A1,
    input  logic [ADDR_W-1:0]             A2,
    input  logic [ADDR_W-1:0]             A3,
    input  logic [LANES-1:0][DATA_W-1:0]  writeData,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ADDR_W-1:0]             out_addr,
    output logic [DATA_W-1:0]             out_data,
    output logic [1:0]                    out_lane,
    output logic [$clog2(DEPTH):0]        level,
    output logic                          idle,
    output logic                          overflow
);
    store_triplet_t push_trip, head;
    logic [1:0]     lane_q, lane_d;
    logic           overflow_q, overflow_d;
    logic           full, empty, beat, pop;
    triplet_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (CLK),
        .rst         (RST),
        .push_i      (MemWriteM),
        .push_data_i (push_trip),
        .pop_i       (pop),
        .head_o      (head),
        .level_o     (level),
        .full_o      (full),
        .empty_o     (empty)
    );
    always_comb begin
        push_trip.addr = {A3, A2, A1};
        push_trip.data = writeData;
        out_valid      = !empty;
        beat           = out_valid && out_ready;
        pop            = beat && lane_q == 2'd2;
        lane_d         = beat ? (pop ? 2'd0 : lane_q + 2'd1) : lane_q;
        // a store arriving while full is lost even if this cycle also pops
        overflow_d     = overflow_q || (MemWriteM && full);
        out_addr       = out_valid ? head.addr[lane_q] : '0;
        out_data       = out_valid ? head.data[lane_q] : '0;
        out_lane       = out_valid ? lane_q : 2'd0;
        idle           = empty;
        overflow       = overflow_q;
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            lane_q     <= 2'd0;
            overflow_q <= 1'b0;
        end else begin
            lane_q     <= lane_d;
            overflow_q <= overflow_d;
        end
    end
endmodule

// File: tb/tb_write_serializer.sv
// tb_write_serializer: queue scoreboard of expected beats, checked by a negedge monitor.
module tb_write_serializer;
    localparam int DEPTH = 8;
    typedef struct packed {
        logic [9:0]  a;
        logic [17:0] d;
        logic [1:0]  l;
    } beat_t;
    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             MemWriteM = 1'b0;
    logic [9:0]       A1 = '0, A2 = '0, A3 = '0;
    logic [2:0][17:0] writeData = '0;
    logic             out_valid, out_ready = 1'b0;
    logic [9:0]       out_addr;
    logic [17:0]      out_data;
    logic [1:0]       out_lane;
    logic [3:0]       level;
    logic             idle, overflow;
    beat_t            exp_q[$];
    int               checks = 0;
    int               errors = 0;
    int               sent;
    write_serializer #(.DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .MemWriteM (MemWriteM),
        .A1        (A1),
        .A2        (A2),
        .A3        (A3),
        .writeData (writeData),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .out_lane  (out_lane),
        .level     (level),
        .idle      (idle),
        .overflow  (overflow)
    );
    always #5 CLK = ~CLK;
    task automatic tick;
        @(posedge CLK);
        #1;
    endtask
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic store(input logic [9:0] a1, input logic [9:0] a2, input logic [9:0] a3,
                         input logic [17:0] d0, input logic [17:0] d1, input logic [17:0] d2,
                         input bit accept);
        MemWriteM    = 1'b1;
        A1           = a1;
        A2           = a2;
        A3           = a3;
        writeData[0] = d0;
        writeData[1] = d1;
        writeData[2] = d2;
        if (accept) begin
            exp_q.push_back({a1, d0, 2'd0});
            exp_q.push_back({a2, d1, 2'd1});
            exp_q.push_back({a3, d2, 2'd2});
        end
    endtask
    task automatic drain(input string name);
        out_ready = 1'b1;
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
        chk(name, exp_q.size(), 0);
    endtask
    // Presented beat must always match the scoreboard head, whether or not it is accepted.
    always @(negedge CLK) begin
        if (!RST && out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected: got a=%h d=%h l=%0d with empty scoreboard",
                         out_addr, out_data, out_lane);
            end else begin
                if ({out_addr, out_data, out_lane} != exp_q[0]) begin
                    errors++;
                    $display("FAIL beat: got a=%h d=%h l=%0d expected a=%h d=%h l=%0d",
                             out_addr, out_data, out_lane, exp_q[0].a, exp_q[0].d, exp_q[0].l);
                end
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end
    initial begin
        tick();
        tick();
        RST = 1'b0;
        chk("reset_valid", out_valid, 0);
        chk("reset_idle", idle, 1);
        chk("reset_level", level, 0);
        chk("reset_overflow", overflow, 0);
        chk("reset_addr", out_addr, 0);
        // single store, ready held high
        out_ready = 1'b1;
        store(10'd5, 10'd6, 10'd7, 18'h00011, 18'h00022, 18'h00033, 1);
        tick();
        MemWriteM = 1'b0;
        chk("single_valid_n1", out_valid, 1);
        chk("single_idle_n1", idle, 0);
        chk("single_level_n1", level, 1);
        tick();
        tick();
        tick();
        chk("single_idle_n4", idle, 1);
        chk("single_q_empty", exp_q.size(), 0);
        // backpressure after lane 0
        store(10'd20, 10'd21, 10'd22, 18'h3ABCD, 18'h01234, 18'h2FFFF, 1);
        tick();
        MemWriteM = 1'b0;
        tick();
        out_ready = 1'b0;
        repeat (4) tick();
        chk("bp_lane_held", out_lane, 1);
        chk("bp_addr_held", out_addr, 21);
        drain("bp_drain");
        // simultaneous push/pop at level 1
        store(10'd100, 10'd101, 10'd102, 18'h00100, 18'h00101, 18'h00102, 1);
        tick();
        MemWriteM = 1'b0;
        tick();
        tick();
        chk("sim_lane2", out_lane, 2);
        store(10'd200, 10'd201, 10'd202, 18'h00200, 18'h00201, 18'h00202, 1);
        tick();
        MemWriteM = 1'b0;
        chk("sim_level", level, 1);
        chk("sim_lane0", out_lane, 0);
        chk("sim_addr", out_addr, 200);
        drain("sim_drain");
        // overflow: nine stores into a stalled FIFO of eight
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            store(10'(300 + i), 10'(400 + i), 10'(500 + i),
                  18'(i * 16 + 1), 18'(i * 16 + 2), 18'(i * 16 + 3), i < 8);
            tick();
        end
        MemWriteM = 1'b0;
        chk("ovf_level", level, 8);
        chk("ovf_flag", overflow, 1);
        drain("ovf_drain");
        chk("ovf_idle", idle, 1);
        chk("ovf_sticky", overflow, 1);
        // reset clears overflow; a store alongside reset is ignored
        RST = 1'b1;
        store(10'd1, 10'd2, 10'd3, 18'd1, 18'd2, 18'd3, 0);
        tick();
        RST = 1'b0;
        MemWriteM = 1'b0;
        chk("rst2_level", level, 0);
        chk("rst2_overflow", overflow, 0);
        chk("rst2_valid", out_valid, 0);
        // wrap-around with random throttling, never offered while full
        sent = 0;
        for (int c = 0; c < 600 && (sent < 20 || exp_q.size() != 0); c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (sent < 20 && exp_q.size() <= 3 * (DEPTH - 1)) begin
                store(10'(600 + sent * 3), 10'(601 + sent * 3), 10'(602 + sent * 3),
                      18'(sent * 1000 + 7), 18'(sent * 1000 + 8), 18'(sent * 1000 + 9), 1);
                sent++;
            end else begin
                MemWriteM = 1'b0;
            end
            tick();
        end
        MemWriteM = 1'b0;
        chk("wrap_sent", sent, 20);
        drain("wrap_drain");
        chk("wrap_overflow", overflow, 0);
        // reset mid-entry after the lane-1 beat of a three-entry queue
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            store(10'(700 + i), 10'(710 + i), 10'(720 + i), 18'(i + 50), 18'(i + 60), 18'(i + 70), 1);
            tick();
        end
        MemWriteM = 1'b0;
        chk("mid_lane2", out_lane, 2);
        RST = 1'b1;
        exp_q.delete();
        tick();
        RST = 1'b0;
        chk("mid_valid", out_valid, 0);
        chk("mid_level", level, 0);
        chk("mid_idle", idle, 1);
        chk("mid_lane", out_lane, 0);
        store(10'd900, 10'd901, 10'd902, 18'h11111, 18'h22222, 18'h33333, 1);
        tick();
        MemWriteM = 1'b0;
        chk("mid_restart_lane", out_lane, 0);
        drain("mid_drain");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/write_serializer.md
# write_serializer

Downstream of the filter processor's memory-write port. Captures every three-lane store (three addresses, three 18-bit data words, one write strobe) into a small FIFO. Replays each store as three single-lane address/data beats on a valid/ready stream. The stream feeds an 18-bit-wide framebuffer/host link, so processed pixels leave the chip without stalling the pipeline.

## Interface
- DEPTH, 8, FIFO capacity in triplet entries; power of two, ≥2
- CLK  in  1  clock, all state on rising edge
- RST  in  1  synchronous, active-high reset
- MemWriteM  in  1  store strobe from processor; one triplet captured per high cycle
- A1, A2, A3  in  10 each  lane 0/1/2 word addresses of the store
- writeData  in  3×18 ([2:0][17:0])  lane data; index 0 pairs with A1, 1 with A2, 2 with A3
- out_valid  out  1  beat available
- out_ready  in  1  sink accepts beat
- out_addr  out  10  beat address
- out_data  out  18  beat data
- out_lane  out  2  lane index of current beat (0..2)
- level  out  $clog2(DEPTH)+1  triplet entries held, including one partly sent
- idle  out  1  level==0
- overflow  out  1  sticky: a store was dropped because FIFO was full

## Operation
- Push: when MemWriteM=1 and level<DEPTH (registered value, this cycle), write {A1,A2,A3,writeData} at wr_ptr; wr_ptr+1 mod DEPTH.
- Push when level==DEPTH: store is discarded and overflow←1. A pop in the same cycle does not rescue it.
- overflow is cleared only by RST.
- Serializer: lane counter lane∈{0,1,2}.
  - out_valid = (level≠0).
  - out_addr/out_data = head entry's lane[lane] address/data.
  - out_lane = lane.
  - When out_valid=0, out_addr, out_data and out_lane are 0.
- Beat transfer when out_valid && out_ready:
  - lane<2: lane+1.
  - lane==2: lane←0, rd_ptr+1 mod DEPTH, entry popped.
- out_ready with out_valid=0 has no effect.
- level update per cycle: +1 on accepted push, −1 on pop, unchanged when both or neither occur.
- Beat order per entry is always lane 0, 1, 2. Entries leave in push order.
- Addresses and data pass through unmodified; there is no address compare or merge. Duplicate addresses emit duplicate beats.

## Timing
- Store captured at edge N: out_valid=1 from cycle N+1 if FIFO was empty. The first beat can transfer in cycle N+1.
- Throughput: 1 beat/cycle with out_ready held high, i.e. 1 triplet per 3 cycles. Sustained stores faster than that fill the FIFO.
- While out_valid=1 and out_ready=0, out_addr, out_data and out_lane are held stable.
- Pointers wrap at DEPTH. Full and empty are distinguished by level, not by pointer equality.
- Reset values:
  - state: wr_ptr=0, rd_ptr=0, lane=0, level=0, overflow=0
  - outputs: out_valid=0, out_addr=0, out_data=0, out_lane=0, idle=1
  - FIFO storage contents need no reset.
- RST asserted mid-entry, e.g. after lane 0 or 1 beat: the partial entry and all queued entries are discarded. The next cycle shows reset values, and lane restarts at 0 for the next store.
- RST has priority over a simultaneous MemWriteM; that store is not captured.

## Structure
- Shared package filter_gpu_pkg holds:
  - LANES=3, DATA_W=18, ADDR_W=10
  - typedef lane_data_t (logic [DATA_W-1:0]) and lane_addr_t
  - packed struct store_triplet_t {addr[LANES], data[LANES]}
- Sub-module triplet_fifo (DEPTH param) holds the storage, pointers, level and full/empty logic. It has push/pop ports of store_triplet_t.
- write_serializer holds lane counter, output muxing, overflow flag.

## Test plan
- Single store: A1=5,A2=6,A3=7, data 0x00011/0x00022/0x00033, out_ready=1 → beats (5,0x11,lane0),(6,0x22,lane1),(7,0x33,lane2) in cycles N+1..N+3; idle back to 1 at N+4.
- Backpressure: out_ready=0 for 4 cycles mid-entry after lane 0 beat → lane1 beat held stable, no beat lost or duplicated when ready returns.
- Overflow: DEPTH=8, out_ready=0, 9 consecutive stores → level=8, overflow=1. Draining yields exactly the first 8 triplets (24 beats) in order.
- Wrap-around: 20 stores with random out_ready throttling, never exceeding full → all 60 beats match scoreboard order; overflow stays 0.
- Simultaneous push/pop at level=1: lane-2 beat accepted in the same cycle as a new store → level stays 1, next beat is lane 0 of the new entry.
- Reset mid-entry: RST after lane-1 beat of a 3-entry queue → next cycle out_valid=0, level=0, idle=1. A subsequent store emits from lane 0.
